// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Packs a valid/ready byte stream into 16-bit words (high byte first) and
// writes them to consecutive addresses. The CPU is held while loading.
// Optional feature: define IMEM_CHECKSUM_EN to add a trailing 2-byte XOR
// checksum check that drives the sticky error output.
module imem_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HI     = 3'd1,
    LO     = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    CHK_HI = 3'd5,
    CHK_LO = 3'd6
  } state_t;

  // word_count value whose write fills the memory
  localparam logic [ADDR_W:0]   FULL_M1 = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi;
  logic              last;
  logic              accept;

`ifdef IMEM_CHECKSUM_EN
  logic [15:0]       csum;
  logic [7:0]        chk_hi;
  logic              error_r;
`endif

  // Handshake and status are pure decodes of the state register, so no
  // input reaches an output combinationally.
  assign in_ready = (state == HI) || (state == LO) ||
                    (state == CHK_HI) || (state == CHK_LO);
  assign accept   = in_valid && in_ready;
  assign mem_we   = (state == WRITE);
  assign done     = (state == DONE);
  assign busy     = (state != IDLE);
  assign cpu_hold = busy;

`ifdef IMEM_CHECKSUM_EN
  assign error = error_r;
`else
  assign error = 1'b0;
`endif

  // Load session FSM: byte packing, address sequencing, counters and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      hi         <= '0;
      last       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      csum       <= '0;
      chk_hi     <= '0;
      error_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr       <= base_addr;
            word_count <= '0;
            overflow   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            csum       <= '0;
            error_r    <= 1'b0;
`endif
            state      <= HI;
          end
        end
        HI: begin
          if (accept) begin
            hi    <= in_data;
            state <= LO;
          end
        end
        LO: begin
          if (accept) begin
            // Write port is loaded here so address/data stay stable
            // outside WRITE even after addr advances.
            mem_addr  <= addr;
            mem_wdata <= {hi, in_data};
            last      <= in_last;
            state     <= WRITE;
          end
        end
        WRITE: begin
          word_count <= word_count + CNT_ONE;
`ifdef IMEM_CHECKSUM_EN
          csum <= csum ^ mem_wdata;
`endif
          if (last) begin
`ifdef IMEM_CHECKSUM_EN
            state <= CHK_HI;
`else
            state <= DONE;
`endif
          end else if (word_count == FULL_M1) begin
            overflow <= 1'b1;
            state    <= DONE;
          end else begin
            addr  <= addr + ADDR_ONE;
            state <= HI;
          end
        end
`ifdef IMEM_CHECKSUM_EN
        CHK_HI: begin
          if (accept) begin
            chk_hi <= in_data;
            state  <= CHK_LO;
          end
        end
        CHK_LO: begin
          if (accept) begin
            error_r <= ({chk_hi, in_data} != csum);
            state   <= DONE;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
